alu8: RTL and testbench



---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_shift_logic.sv | 31 +++
 rtl/alu8.sv | 93 +++++++++
 tb/tb_alu8.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the alu8 execute stage.
// Opcode encoding is fixed at 4 bits; all 16 values are defined operations.
package alu_pkg;

    localparam int ALU_W = 8;
    localparam logic [ALU_W-1:0] DIV0_RESULT = 8'hFF;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_SHL  = 4'd4,
        OP_SHR  = 4'd5,
        OP_ROL  = 4'd6,
        OP_ROR  = 4'd7,
        OP_AND  = 4'd8,
        OP_OR   = 4'd9,
        OP_XOR  = 4'd10,
        OP_NOR  = 4'd11,
        OP_NAND = 4'd12,
        OP_XNOR = 4'd13,
        OP_GT   = 4'd14,
        OP_EQ   = 4'd15
    } alu_op_e;

endpackage

// File: rtl/alu_shift_logic.sv
// Combinational shift/rotate, bitwise and compare unit for opcodes 4-15.
// Opcodes 0-3 belong to the arithmetic path in the top level and return zero here.
module alu_shift_logic
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] i_a,
    input  logic [ALU_W-1:0] i_b,
    input  alu_op_e          i_sel,
    output logic [ALU_W-1:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_sel)
            OP_SHL:  o_result = {i_a[6:0], 1'b0};
            OP_SHR:  o_result = {1'b0, i_a[7:1]};
            OP_ROL:  o_result = {i_a[6:0], i_a[7]};
            OP_ROR:  o_result = {i_a[0], i_a[7:1]};
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_NOR:  o_result = ~(i_a | i_b);
            OP_NAND: o_result = ~(i_a & i_b);
            OP_XNOR: o_result = ~(i_a ^ i_b);
            OP_GT:   o_result = {7'd0, (i_a > i_b)};
            OP_EQ:   o_result = {7'd0, (i_a == i_b)};
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu8.sv
// 8-bit registered ALU: arithmetic, result mux and output registers.
// Macro ALU_MULDIV_EN enables the single-cycle multiplier and divider (opcodes 2/3).
module alu8
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ALU_W-1:0] A,
    input  logic [ALU_W-1:0] B,
    input  logic [3:0]       ALU_Sel,
    output logic [ALU_W-1:0] ALU_Out,
    output logic             CarryOut
);

    alu_op_e          w_op;
    logic [ALU_W:0]   w_sum;
    logic [ALU_W:0]   w_diff;
    logic [ALU_W-1:0] w_logic_out;
    logic [ALU_W-1:0] w_next_out;
    logic             w_next_carry;
    logic [ALU_W-1:0] r_out;
    logic             r_carry;

    assign w_op   = alu_op_e'(ALU_Sel);
    assign w_sum  = {1'b0, A} + {1'b0, B};
    // Bit 8 of the 9-bit difference is the borrow, set exactly when A < B.
    assign w_diff = {1'b0, A} - {1'b0, B};

`ifdef ALU_MULDIV_EN
    logic [2*ALU_W-1:0] w_prod;
    logic [ALU_W-1:0]   w_quot;
    logic               w_div0;

    assign w_prod = {8'd0, A} * {8'd0, B};
    assign w_div0 = (B == '0);
    assign w_quot = w_div0 ? DIV0_RESULT : (A / B);
`endif

    alu_shift_logic u_shift_logic (
        .i_a      (A),
        .i_b      (B),
        .i_sel    (w_op),
        .o_result (w_logic_out)
    );

    always_comb begin
        w_next_out   = w_logic_out;
        w_next_carry = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_next_out   = w_sum[ALU_W-1:0];
                w_next_carry = w_sum[ALU_W];
            end
            OP_SUB: begin
                w_next_out   = w_diff[ALU_W-1:0];
                w_next_carry = w_diff[ALU_W];
            end
`ifdef ALU_MULDIV_EN
            OP_MUL: begin
                w_next_out   = w_prod[ALU_W-1:0];
                w_next_carry = |w_prod[2*ALU_W-1:ALU_W];
            end
            OP_DIV: begin
                w_next_out   = w_quot;
                w_next_carry = w_div0;
            end
`else
            OP_MUL, OP_DIV: begin
                w_next_out   = '0;
                w_next_carry = 1'b0;
            end
`endif
            default: begin
                w_next_out   = w_logic_out;
                w_next_carry = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_carry <= 1'b0;
        end else begin
            r_out   <= w_next_out;
            r_carry <= w_next_carry;
        end
    end

    assign ALU_Out  = r_out;
    assign CarryOut = r_carry;

endmodule

// File: tb/tb_alu8.sv
// Self-checking bench for alu8: directed reset/boundary steps plus random ops
// against an arithmetic reference model; honours ALU_MULDIV_EN like the RTL.
module tb_alu8;

    logic       clk;
    logic       rst_n;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] ALU_Sel;
    logic [7:0] ALU_Out;
    logic       CarryOut;

    int n_cmp;
    int n_err;

    alu8 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .B        (B),
        .ALU_Sel  (ALU_Sel),
        .ALU_Out  (ALU_Out),
        .CarryOut (CarryOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ALU_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    // Reference: {carry, result} from integer arithmetic on the operation rules.
    function automatic logic [8:0] model(input int a, input int b, input int sel);
        int r;
        int c;
        r = 0;
        c = 0;
        case (sel)
            0: begin r = (a + b) % 256; c = ((a + b) > 255) ? 1 : 0; end
            1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            2: if (MULDIV) begin r = (a * b) % 256; c = ((a * b) >= 256) ? 1 : 0; end
            3: if (MULDIV) begin
                   if (b == 0) begin r = 255; c = 1; end
                   else r = a / b;
               end
            4: r = (a * 2) % 256;
            5: r = a / 2;
            6: r = (a * 2) % 256 + a / 128;
            7: r = a / 2 + (a % 2) * 128;
            8: r = a & b;
            9: r = a | b;
            10: r = a ^ b;
            11: r = 255 - (a | b);
            12: r = 255 - (a & b);
            13: r = 255 - (a ^ b);
            14: r = (a > b) ? 1 : 0;
            15: r = (a == b) ? 1 : 0;
            default: r = 0;
        endcase
        return {c[0], r[7:0]};
    endfunction

    task automatic check(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {CarryOut, ALU_Out};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed carry=%0b out=%0d, expected carry=%0b out=%0d",
                   tag, obs[8], obs[7:0], exp[8], exp[7:0]);
        end
    endtask

    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        @(negedge clk);
        A       = a;
        B       = b;
        ALU_Sel = sel;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sweep [16];
        logic [7:0] ra;
        logic [7:0] rb;
        logic [3:0] rs;

        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b1;
        A       = 8'd77;
        B       = 8'd201;
        ALU_Sel = 4'd0;

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1 check("reset_async", 9'h000);
        @(posedge clk);
        #1 check("reset_held_edge", 9'h000);

        // Release and check capture on the very next edge.
        @(negedge clk);
        rst_n   = 1'b1;
        A       = 8'd3;
        B       = 8'd4;
        ALU_Sel = 4'd0;
        @(posedge clk);
        #1 check("release_capture", 9'd7);

        // Sweep A=15, B=1 across all opcodes.
        sweep = '{16, 14, 15, 15, 30, 7, 30, 135, 1, 15, 14, 240, 254, 241, 1, 0};
        if (!MULDIV) begin
            sweep[2] = 0;
            sweep[3] = 0;
        end
        for (int op = 0; op < 16; op++) begin
            step(8'd15, 8'd1, op[3:0]);
            check($sformatf("sweep_op%0d", op), {1'b0, 8'(sweep[op])});
        end

        // Carry / borrow boundaries.
        step(8'd255, 8'd1, 4'd0);  check("add_carry", {1'b1, 8'd0});
        step(8'd0, 8'd1, 4'd1);    check("sub_borrow", {1'b1, 8'd255});
        step(8'd16, 8'd16, 4'd2);  check("mul_overflow", MULDIV ? {1'b1, 8'd0} : 9'd0);
        step(8'd37, 8'd0, 4'd3);   check("div_by_zero", MULDIV ? {1'b1, 8'd255} : 9'd0);
        step(8'd37, 8'd5, 4'd3);   check("div_37_5", MULDIV ? {1'b0, 8'd7} : 9'd0);
        step(8'd3, 8'd4, 4'd2);    check("mul_3_4", MULDIV ? {1'b0, 8'd12} : 9'd0);
        step(8'd8, 8'd2, 4'd3);    check("div_8_2", MULDIV ? {1'b0, 8'd4} : 9'd0);

        // Compares and rotates.
        step(8'd200, 8'd100, 4'd14); check("gt_200_100", 9'd1);
        step(8'd90, 8'd90, 4'd15);   check("eq_90_90", 9'd1);
        step(8'd5, 8'd5, 4'd14);     check("gt_5_5", 9'd0);
        step(8'h81, 8'd0, 4'd6);     check("rol_81", 9'h003);
        step(8'h81, 8'd0, 4'd7);     check("ror_81", 9'h0C0);

        // Mid-stream reset clears a non-zero, carry-set result without a clock edge.
        step(8'd255, 8'd255, 4'd0);  check("pre_reset_add", {1'b1, 8'd254});
        #2 rst_n = 1'b0;
        #1 check("reset_midstream", 9'h000);
        @(negedge clk);
        rst_n = 1'b1;

        // Random operations against the model.
        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (i % 10 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            rs = 4'($urandom_range(0, 15));
            step(ra, rb, rs);
            check($sformatf("rand%0d_op%0d_a%0d_b%0d", i, rs, ra, rb),
                  model(int'(ra), int'(rb), int'(rs)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
